// File: rtl/clk_phase_monitor.sv
// ============================================================================
// Module      : clk_phase_monitor
// Description : Oversamples a clock pair with a reference clock, measures the
//               A period and A-to-B lag, and flags lock/phase/miss/stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_phase_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_LAG  = 2,
    parameter int LAG_TOL  = 0,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic             i_ref_ck,
    input  logic             i_ref_rst_n,
    input  logic             i_ck_a,
    input  logic             i_ck_b,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_lag,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_phase_err,
    output logic             o_miss_b,
    output logic             o_stall
);

    localparam int               LC_W       = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   c_exp_lag  = (CNT_W + 1)'(EXP_LAG);
    localparam logic [CNT_W:0]   c_lag_tol  = (CNT_W + 1)'(LAG_TOL);
    localparam logic [LC_W-1:0]  c_lock_max = LC_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_B = 2'd1,
        ST_WAIT_A = 2'd2
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic              r_a_s1, r_a_s2, r_a_prev;
    logic              r_b_s1, r_b_s2, r_b_prev;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [CNT_W-1:0]  r_lag_cap,  w_lag_cap_nxt;
    logic [CNT_W-1:0]  r_period,   w_period_nxt;
    logic [CNT_W-1:0]  r_lag,      w_lag_nxt;
    logic [LC_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
    logic              r_valid,    w_valid_nxt;
    logic              r_lock,     w_lock_nxt;
    logic              r_err,      w_err_nxt;
    logic              r_miss,     w_miss_nxt;
    logic              r_stall,    w_stall_nxt;
    logic              w_rise_a, w_rise_b, w_publish, w_in_win;
    logic [CNT_W-1:0]  w_pub_lag;
    logic [CNT_W:0]    w_lag_x, w_diff;

    // Two-stage synchronizer plus one history flop per input
    always_ff @(posedge i_ref_ck) begin
        if (!i_ref_rst_n) begin
            {r_a_s1, r_a_s2, r_a_prev} <= 3'b000;
            {r_b_s1, r_b_s2, r_b_prev} <= 3'b000;
        end else begin
            {r_a_s1, r_a_s2, r_a_prev} <= {i_ck_a, r_a_s1, r_a_s2};
            {r_b_s1, r_b_s2, r_b_prev} <= {i_ck_b, r_b_s1, r_b_s2};
        end
    end

    assign w_rise_a = r_a_s2 & ~r_a_prev;
    assign w_rise_b = r_b_s2 & ~r_b_prev;

    // A coincident A/B edge seen while waiting for B publishes a zero lag
    assign w_pub_lag = (r_state == ST_WAIT_B) ? '0 : r_lag_cap;
    assign w_lag_x   = {1'b0, w_pub_lag};
    assign w_diff    = (w_lag_x >= c_exp_lag) ? (w_lag_x - c_exp_lag) : (c_exp_lag - w_lag_x);
    assign w_in_win  = (w_diff <= c_lag_tol);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_rise_a ? c_cnt_one :
                         ((r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one);
        w_lag_cap_nxt  = r_lag_cap;
        w_period_nxt   = r_period;
        w_lag_nxt      = r_lag;
        w_lock_cnt_nxt = r_lock_cnt;
        w_valid_nxt    = 1'b0;
        w_lock_nxt     = r_lock;
        w_err_nxt      = r_err;
        w_miss_nxt     = 1'b0;
        w_stall_nxt    = w_rise_a ? 1'b0 : r_stall;
        w_publish      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise_a) w_state_nxt = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (w_rise_a && w_rise_b) begin
                    w_publish     = 1'b1;
                    w_lag_cap_nxt = '0;
                    w_state_nxt   = ST_WAIT_A;
                end else if (w_rise_a) begin
                    w_miss_nxt     = 1'b1;
                    w_period_nxt   = r_cnt;
                    w_lock_cnt_nxt = '0;
                    w_lock_nxt     = 1'b0;
                end else if (w_rise_b) begin
                    w_lag_cap_nxt = r_cnt;
                    w_state_nxt   = ST_WAIT_A;
                end else if (r_cnt == c_timeout) begin
                    w_stall_nxt    = 1'b1;
                    w_lock_cnt_nxt = '0;
                    w_lock_nxt     = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_WAIT_A: begin
                if (w_rise_a) begin
                    w_publish   = 1'b1;
                    w_state_nxt = ST_WAIT_B;
                end else if (r_cnt == c_timeout) begin
                    w_stall_nxt    = 1'b1;
                    w_lock_cnt_nxt = '0;
                    w_lock_nxt     = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_publish) begin
            w_period_nxt = r_cnt;
            w_lag_nxt    = w_pub_lag;
            w_valid_nxt  = 1'b1;
            if (w_in_win) begin
                w_lock_cnt_nxt = (r_lock_cnt == c_lock_max) ? r_lock_cnt : r_lock_cnt + LC_W'(1);
                w_lock_nxt     = (w_lock_cnt_nxt == c_lock_max);
            end else begin
                w_err_nxt      = 1'b1;
                w_lock_cnt_nxt = '0;
                w_lock_nxt     = 1'b0;
            end
        end
    end

    always_ff @(posedge i_ref_ck) begin
        if (!i_ref_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lag_cap  <= '0;
            r_period   <= '0;
            r_lag      <= '0;
            r_lock_cnt <= '0;
            r_valid    <= 1'b0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
            r_miss     <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lag_cap  <= w_lag_cap_nxt;
            r_period   <= w_period_nxt;
            r_lag      <= w_lag_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_valid    <= w_valid_nxt;
            r_lock     <= w_lock_nxt;
            r_err      <= w_err_nxt;
            r_miss     <= w_miss_nxt;
            r_stall    <= w_stall_nxt;
        end
    end

    assign o_period    = r_period;
    assign o_lag       = r_lag;
    assign o_valid     = r_valid;
    assign o_lock      = r_lock;
    assign o_phase_err = r_err;
    assign o_miss_b    = r_miss;
    assign o_stall     = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_clk_phase_monitor.sv
// ============================================================================
// Module      : tb_clk_phase_monitor
// Description : Directed self-checking bench for clk_phase_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_phase_monitor;

    logic       ref_ck = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rst2_n = 1'b0;
    logic       ck_a = 1'b0, ck_b = 1'b0, ck_a2 = 1'b0, ck_b2 = 1'b0;
    logic [7:0] period, lag, period2, lag2;
    logic       valid, lock, perr, miss, stall;
    logic       valid2, lock2, perr2, miss2, stall2;

    int         n_cmp = 0;
    int         n_err = 0;
    int         k = 0;
    int         delay = 2;
    logic       a_en = 1'b0;
    logic       b_force0 = 1'b0;
    logic       rst_req = 1'b0;
    logic [7:0] hist = '0;

    int v_period[$], v_lag[$], v_lock[$], v_err[$];
    int w_period[$], w_lag[$], w_lock[$];
    int n_miss = 0, n_both = 0, miss_period = -1, miss_lock = -1;
    int nv;

    clk_phase_monitor dut (
        .i_ref_ck(ref_ck), .i_ref_rst_n(rst_n), .i_ck_a(ck_a), .i_ck_b(ck_b),
        .o_period(period), .o_lag(lag), .o_valid(valid), .o_lock(lock),
        .o_phase_err(perr), .o_miss_b(miss), .o_stall(stall)
    );

    clk_phase_monitor #(.LAG_TOL(2)) dut_zero (
        .i_ref_ck(ref_ck), .i_ref_rst_n(rst2_n), .i_ck_a(ck_a2), .i_ck_b(ck_b2),
        .o_period(period2), .o_lag(lag2), .o_valid(valid2), .o_lock(lock2),
        .o_phase_err(perr2), .o_miss_b(miss2), .o_stall(stall2)
    );

    always #5 ref_ck = ~ref_ck;

    always @(negedge ref_ck) begin
        if (valid === 1'b1) begin
            v_period.push_back(int'(period));
            v_lag.push_back(int'(lag));
            v_lock.push_back(int'(lock));
            v_err.push_back(int'(perr));
        end
        if (miss === 1'b1) begin
            n_miss++;
            miss_period = int'(period);
            miss_lock   = int'(lock);
        end
        if (valid === 1'b1 && miss === 1'b1) n_both++;
        if (valid2 === 1'b1) begin
            w_period.push_back(int'(period2));
            w_lag.push_back(int'(lag2));
            w_lock.push_back(int'(lock2));
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // One reference cycle: drive both pairs on the falling edge
    task automatic step();
        logic a, b;
        @(negedge ref_ck);
        a        = a_en && ((k % 8) < 4);
        b        = b_force0 ? 1'b0 : hist[delay-1];
        hist     = {hist[6:0], a};
        ck_a     = a;
        ck_b     = b;
        ck_a2    = ((k % 8) < 4);
        ck_b2    = ck_a2;
        rst_n    = rst_req;
        rst2_n   = (k >= 8);
        k++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (k < n) step();
    endtask

    initial begin
        // Reset state
        run_to(8);
        check_val("rst_period", period, 0);
        check_val("rst_lag",    lag,    0);
        check_val("rst_valid",  valid,  0);
        check_val("rst_lock",   lock,   0);
        check_val("rst_perr",   perr,   0);
        check_val("rst_miss",   miss,   0);
        check_val("rst_stall",  stall,  0);

        // Steady pair: period 8, lag 2
        rst_req = 1'b1;
        a_en    = 1'b1;
        run_to(80);
        check_val("p1_nvalid",  v_period.size(), 8);
        check_val("p1_period0", qget(v_period, 0), 8);
        check_val("p1_lag0",    qget(v_lag, 0), 2);
        check_val("p1_lock2",   qget(v_lock, 2), 0);
        check_val("p1_lock3",   qget(v_lock, 3), 1);
        check_val("p1_period7", qget(v_period, 7), 8);
        check_val("p1_lag7",    qget(v_lag, 7), 2);
        check_val("p1_perr",    perr, 0);

        // One period at lag 3, then back to lag 2
        delay = 3;
        run_to(88);
        delay = 2;
        run_to(128);
        check_val("p2_lag_bad",   qget(v_lag, 9), 3);
        check_val("p2_err_bad",   qget(v_err, 9), 1);
        check_val("p2_lock_bad",  qget(v_lock, 9), 0);
        check_val("p2_lock_3rd",  qget(v_lock, 12), 0);
        check_val("p2_lock_4th",  qget(v_lock, 13), 1);
        check_val("p2_err_stick", qget(v_err, 13), 1);
        check_val("p2_lag_good",  qget(v_lag, 13), 2);

        // B missing for one A period
        b_force0 = 1'b1;
        run_to(136);
        b_force0 = 1'b0;
        run_to(152);
        check_val("p3_nmiss",      n_miss, 1);
        check_val("p3_miss_per",   miss_period, 8);
        check_val("p3_miss_lock",  miss_lock, 0);
        check_val("p3_nvalid",     v_period.size(), 16);
        check_val("p3_resume_per", qget(v_period, 15), 8);
        check_val("p3_resume_lk",  qget(v_lock, 15), 0);

        // A held low: stall exactly when the counter reaches 64
        a_en = 1'b0;
        run_to(211);
        check_val("p4_stall_pre", stall, 0);
        run_to(212);
        check_val("p4_stall",     stall, 1);
        check_val("p4_stall_lk",  lock, 0);
        run_to(224);
        check_val("p4_nvalid_hold", v_period.size(), 16);
        a_en = 1'b1;
        run_to(240);
        check_val("p4_stall_clr", stall, 0);
        check_val("p4_nvalid",    v_period.size(), 17);
        check_val("p4_period",    qget(v_period, 16), 8);
        check_val("p4_lag",       qget(v_lag, 16), 2);

        // Reset between an A rise and its B rise
        run_to(267);
        rst_req = 1'b0;
        step();
        check_val("p5_lock_pre",  lock, 1);
        check_val("p5_valid_pre", valid, 1);
        rst_req = 1'b1;
        step();
        check_val("p5_rst_period", period, 0);
        check_val("p5_rst_lag",    lag, 0);
        check_val("p5_rst_valid",  valid, 0);
        check_val("p5_rst_lock",   lock, 0);
        check_val("p5_rst_perr",   perr, 0);
        check_val("p5_rst_stall",  stall, 0);
        nv = v_period.size();
        run_to(282);
        check_val("p5_no_valid", v_period.size(), nv);
        run_to(285);
        check_val("p5_valid",  v_period.size(), nv + 1);
        check_val("p5_period", qget(v_period, nv), 8);
        check_val("p5_lag",    qget(v_lag, nv), 2);

        // Zero-shift instance with widened window
        check_val("z_period0", qget(w_period, 0), 8);
        check_val("z_lag0",    qget(w_lag, 0), 0);
        check_val("z_lag5",    qget(w_lag, 5), 0);
        check_val("z_lock2",   qget(w_lock, 2), 0);
        check_val("z_lock3",   qget(w_lock, 3), 1);
        check_val("z_perr",    perr2, 0);

        check_val("valid_and_miss", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
